// File: rtl/powerup_ctrl.sv
// Speed power-up scheduler shared by both tanks: spawn delay, pseudo-random placement,
// collision arbitration between the two tanks and a timed speed_upgrade pulse.
module powerup_ctrl #(
    parameter int unsigned SPAWN_DELAY    = 600,
    parameter int unsigned DESPAWN_FRAMES = 450,
    parameter int unsigned ACTIVE_FRAMES  = 300,
    parameter int unsigned PU_SIZE        = 6,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       game_active,
    input  logic [9:0] p1_x,
    input  logic [9:0] p1_y,
    input  logic [9:0] p1_s,
    input  logic [9:0] p2_x,
    input  logic [9:0] p2_y,
    input  logic [9:0] p2_s,
    output logic       pu_visible,
    output logic [9:0] pu_x,
    output logic [9:0] pu_y,
    output logic       speed_upgrade_p1,
    output logic       speed_upgrade_p2,
    output logic [9:0] frames_left
);

    typedef enum logic [1:0] {StWait, StSpawned, StActive} state_e;

    localparam logic [9:0]  SpawnCnt   = 10'(SPAWN_DELAY);
    localparam logic [9:0]  DespawnCnt = 10'(DESPAWN_FRAMES);
    localparam logic [9:0]  ActiveCnt  = 10'(ACTIVE_FRAMES);
    localparam logic [10:0] PuReach    = 11'(PU_SIZE);

    state_e      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        tie_pri_q, tie_pri_d;
    logic        vis_q, vis_d;
    logic [9:0]  pu_x_q, pu_x_d;
    logic [9:0]  pu_y_q, pu_y_d;
    logic        up1_q, up1_d;
    logic        up2_q, up2_d;
    logic        hit1, hit2;

    // Widen to 11 bits before subtracting so the distance and reach never wrap.
    function automatic logic in_reach(input logic [9:0] px, input logic [9:0] py,
                                      input logic [9:0] ps, input logic [9:0] cx,
                                      input logic [9:0] cy);
        logic [10:0] dx, dy, reach;
        dx    = (px >= cx) ? ({1'b0, px} - {1'b0, cx}) : ({1'b0, cx} - {1'b0, px});
        dy    = (py >= cy) ? ({1'b0, py} - {1'b0, cy}) : ({1'b0, cy} - {1'b0, py});
        reach = {1'b0, ps} + PuReach;
        return (dx <= reach) && (dy <= reach);
    endfunction

    assign hit1 = in_reach(p1_x, p1_y, p1_s, pu_x_q, pu_y_q);
    assign hit2 = in_reach(p2_x, p2_y, p2_s, pu_x_q, pu_y_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tie_pri_d = tie_pri_q;
        vis_d     = vis_q;
        pu_x_d    = pu_x_q;
        pu_y_d    = pu_y_q;
        up1_d     = up1_q;
        up2_d     = up2_q;
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        if (!game_active) begin
            state_d = StWait;
            cnt_d   = SpawnCnt;
            vis_d   = 1'b0;
            up1_d   = 1'b0;
            up2_d   = 1'b0;
        end else begin
            case (state_q)
                StWait: begin
                    if (cnt_q == 10'd1) begin
                        // Placement uses the pre-shift LFSR value.
                        pu_x_d  = 10'd64 + {1'b0, lfsr_q[8:0]};
                        pu_y_d  = 10'd112 + {2'b0, lfsr_q[15:8]};
                        vis_d   = 1'b1;
                        cnt_d   = DespawnCnt;
                        state_d = StSpawned;
                    end else begin
                        cnt_d = cnt_q - 10'd1;
                    end
                end
                StSpawned: begin
                    if (hit1 || hit2) begin
                        if (hit1 && hit2) begin
                            up1_d     = ~tie_pri_q;
                            up2_d     = tie_pri_q;
                            tie_pri_d = ~tie_pri_q;
                        end else begin
                            up1_d = hit1;
                            up2_d = hit2;
                        end
                        vis_d   = 1'b0;
                        cnt_d   = ActiveCnt;
                        state_d = StActive;
                    end else if (cnt_q == 10'd1) begin
                        vis_d   = 1'b0;
                        cnt_d   = SpawnCnt;
                        state_d = StWait;
                    end else begin
                        cnt_d = cnt_q - 10'd1;
                    end
                end
                StActive: begin
                    if (cnt_q == 10'd1) begin
                        up1_d   = 1'b0;
                        up2_d   = 1'b0;
                        cnt_d   = SpawnCnt;
                        state_d = StWait;
                    end else begin
                        cnt_d = cnt_q - 10'd1;
                    end
                end
                default: begin
                    vis_d   = 1'b0;
                    up1_d   = 1'b0;
                    up2_d   = 1'b0;
                    cnt_d   = SpawnCnt;
                    state_d = StWait;
                end
            endcase
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= StWait;
            cnt_q     <= SpawnCnt;
            lfsr_q    <= LFSR_SEED;
            tie_pri_q <= 1'b0;
            vis_q     <= 1'b0;
            pu_x_q    <= 10'd0;
            pu_y_q    <= 10'd0;
            up1_q     <= 1'b0;
            up2_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            tie_pri_q <= tie_pri_d;
            vis_q     <= vis_d;
            pu_x_q    <= pu_x_d;
            pu_y_q    <= pu_y_d;
            up1_q     <= up1_d;
            up2_q     <= up2_d;
        end
    end

    assign pu_visible       = vis_q;
    assign pu_x             = pu_x_q;
    assign pu_y             = pu_y_q;
    assign speed_upgrade_p1 = up1_q;
    assign speed_upgrade_p2 = up2_q;
    assign frames_left      = cnt_q;

endmodule

// File: tb/tb_powerup_ctrl.sv
// Bench for powerup_ctrl: directed scenarios plus randomized frames against a frame-level
// reference model of the power-up cycle.
module tb_powerup_ctrl;

    localparam int SPAWN   = 4;
    localparam int DESPAWN = 5;
    localparam int ACTIVE  = 3;
    localparam int PUS     = 6;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       game_active;
    logic [9:0] p1_x, p1_y, p1_s, p2_x, p2_y, p2_s;
    logic       pu_visible;
    logic [9:0] pu_x, pu_y;
    logic       speed_upgrade_p1, speed_upgrade_p2;
    logic [9:0] frames_left;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 waiting, 1 pickup shown, 2 boost running.
    int          m_phase, m_cnt, m_pux, m_puy;
    bit          m_vis, m_up1, m_up2, m_tie;
    logic [15:0] m_lfsr;

    powerup_ctrl #(
        .SPAWN_DELAY   (SPAWN),
        .DESPAWN_FRAMES(DESPAWN),
        .ACTIVE_FRAMES (ACTIVE),
        .PU_SIZE       (PUS),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .frame_clk       (frame_clk),
        .Reset           (Reset),
        .game_active     (game_active),
        .p1_x            (p1_x),
        .p1_y            (p1_y),
        .p1_s            (p1_s),
        .p2_x            (p2_x),
        .p2_y            (p2_y),
        .p2_s            (p2_s),
        .pu_visible      (pu_visible),
        .pu_x            (pu_x),
        .pu_y            (pu_y),
        .speed_upgrade_p1(speed_upgrade_p1),
        .speed_upgrade_p2(speed_upgrade_p2),
        .frames_left     (frames_left)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic bit near(int px, int py, int ps, int cx, int cy);
        int dx = (px > cx) ? px - cx : cx - px;
        int dy = (py > cy) ? py - cy : cy - py;
        return (dx <= ps + PUS) && (dy <= ps + PUS);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = SPAWN; m_lfsr = 16'hACE1; m_tie = 0;
        m_vis = 0; m_pux = 0; m_puy = 0; m_up1 = 0; m_up2 = 0;
    endtask

    task automatic model_step();
        int parity = int'(m_lfsr[15]) + int'(m_lfsr[13]) + int'(m_lfsr[12]) + int'(m_lfsr[10]);
        int nxt = ((int'(m_lfsr) * 2) % 65536) + (parity % 2);
        bit h1 = near(p1_x, p1_y, p1_s, m_pux, m_puy);
        bit h2 = near(p2_x, p2_y, p2_s, m_pux, m_puy);
        if (!game_active) begin
            m_phase = 0; m_cnt = SPAWN; m_vis = 0; m_up1 = 0; m_up2 = 0;
        end else if (m_phase == 0) begin
            if (m_cnt == 1) begin
                m_pux = 64 + int'(m_lfsr) % 512;
                m_puy = 112 + int'(m_lfsr) / 256;
                m_vis = 1; m_cnt = DESPAWN; m_phase = 1;
            end else m_cnt--;
        end else if (m_phase == 1) begin
            if (h1 || h2) begin
                if (h1 && h2) begin
                    if (m_tie) m_up2 = 1; else m_up1 = 1;
                    m_tie = !m_tie;
                end else if (h1) m_up1 = 1;
                else m_up2 = 1;
                m_vis = 0; m_cnt = ACTIVE; m_phase = 2;
            end else if (m_cnt == 1) begin
                m_vis = 0; m_cnt = SPAWN; m_phase = 0;
            end else m_cnt--;
        end else begin
            if (m_cnt == 1) begin
                m_up1 = 0; m_up2 = 0; m_cnt = SPAWN; m_phase = 0;
            end else m_cnt--;
        end
        m_lfsr = 16'(nxt);
    endtask

    task automatic tick();
        @(posedge frame_clk);
        model_step();
        #1;
    endtask

    task automatic far();
        p1_x = 10'd20;  p1_y = 10'd20;  p1_s = 10'd8;
        p2_x = 10'd620; p2_y = 10'd460; p2_s = 10'd8;
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        model_reset();
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic wait_spawn();
        for (int i = 0; i < 3 * SPAWN && !m_vis; i++) tick();
    endtask

    task automatic test_reset();
        game_active = 1'b1;
        far();
        Reset = 1'b1;
        model_reset();
        #1;
        checks++; if (pu_visible !== 1'b0) begin errors++;
            $display("FAIL reset_vis: got %0b expected 0", pu_visible); end
        checks++; if (pu_x !== 10'd0 || pu_y !== 10'd0) begin errors++;
            $display("FAIL reset_pos: got %0d,%0d expected 0,0", pu_x, pu_y); end
        checks++; if (speed_upgrade_p1 !== 1'b0 || speed_upgrade_p2 !== 1'b0) begin errors++;
            $display("FAIL reset_up: got %0b%0b expected 00", speed_upgrade_p1,
                     speed_upgrade_p2); end
        checks++; if (frames_left !== 10'(SPAWN)) begin errors++;
            $display("FAIL reset_frames: got %0d expected %0d", frames_left, SPAWN); end
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic test_spawn();
        apply_reset();
        for (int i = 1; i <= SPAWN; i++) begin
            tick();
            checks++; if (pu_visible !== (i == SPAWN)) begin errors++;
                $display("FAIL spawn_vis edge %0d: got %0b expected %0b", i, pu_visible,
                         i == SPAWN); end
            checks++; if (frames_left !== 10'((i < SPAWN) ? SPAWN - i : DESPAWN)) begin
                errors++;
                $display("FAIL spawn_frames edge %0d: got %0d", i, frames_left); end
        end
        checks++; if (pu_x !== 10'(m_pux) || pu_y !== 10'(m_puy)) begin errors++;
            $display("FAIL spawn_pos: got %0d,%0d expected %0d,%0d", pu_x, pu_y, m_pux,
                     m_puy); end
        checks++; if (pu_x < 10'd64 || pu_x > 10'd575 || pu_y < 10'd112 || pu_y > 10'd367)
        begin errors++;
            $display("FAIL spawn_range: got %0d,%0d", pu_x, pu_y); end
    endtask

    task automatic test_collect();
        p1_x = 10'(m_pux + 14); p1_y = 10'(m_puy);
        tick();
        checks++; if (speed_upgrade_p1 !== 1'b1 || pu_visible !== 1'b0) begin errors++;
            $display("FAIL collect_14: got up1=%0b vis=%0b expected up1=1 vis=0",
                     speed_upgrade_p1, pu_visible); end
        far();
        for (int i = 1; i <= ACTIVE; i++) begin
            tick();
            checks++; if (speed_upgrade_p1 !== (i < ACTIVE)) begin errors++;
                $display("FAIL active_len edge %0d: got %0b expected %0b", i,
                         speed_upgrade_p1, i < ACTIVE); end
        end
        checks++; if (frames_left !== 10'(SPAWN)) begin errors++;
            $display("FAIL active_reload: got %0d expected %0d", frames_left, SPAWN); end
        wait_spawn();
        p1_x = 10'(m_pux + 15); p1_y = 10'(m_puy);
        tick();
        checks++; if (pu_visible !== 1'b1 || speed_upgrade_p1 !== 1'b0) begin errors++;
            $display("FAIL miss_15x: got vis=%0b up1=%0b expected vis=1 up1=0",
                     pu_visible, speed_upgrade_p1); end
        p1_x = 10'(m_pux); p1_y = 10'(m_puy - 15);
        tick();
        checks++; if (pu_visible !== 1'b1 || speed_upgrade_p1 !== 1'b0) begin errors++;
            $display("FAIL miss_15y: got vis=%0b up1=%0b expected vis=1 up1=0",
                     pu_visible, speed_upgrade_p1); end
        far();
    endtask

    task automatic test_tie();
        bit exp_p1;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            wait_spawn();
            p1_x = 10'(m_pux); p1_y = 10'(m_puy);
            p2_x = 10'(m_pux + 3); p2_y = 10'(m_puy - 3);
            tick();
            exp_p1 = (k != 1);
            checks++; if (speed_upgrade_p1 !== exp_p1 || speed_upgrade_p2 !== !exp_p1) begin
                errors++;
                $display("FAIL tie_%0d: got %0b%0b expected %0b%0b", k, speed_upgrade_p1,
                         speed_upgrade_p2, exp_p1, !exp_p1); end
            far();
            for (int i = 0; i < ACTIVE; i++) tick();
        end
    endtask

    task automatic test_despawn();
        int hi = 0;
        bit any_up = 0;
        apply_reset();
        far();
        wait_spawn();
        for (int i = 0; i < 3 * DESPAWN && pu_visible; i++) begin
            hi++;
            any_up |= speed_upgrade_p1 | speed_upgrade_p2;
            tick();
        end
        any_up |= speed_upgrade_p1 | speed_upgrade_p2;
        checks++; if (hi != DESPAWN) begin errors++;
            $display("FAIL despawn_len: got %0d expected %0d", hi, DESPAWN); end
        checks++; if (frames_left !== 10'(SPAWN)) begin errors++;
            $display("FAIL despawn_reload: got %0d expected %0d", frames_left, SPAWN); end
        checks++; if (any_up !== 1'b0) begin errors++;
            $display("FAIL despawn_up: got %0b expected 0", any_up); end
    endtask

    task automatic test_game_inactive();
        apply_reset();
        far();
        wait_spawn();
        p2_x = 10'(m_pux); p2_y = 10'(m_puy);
        tick();
        far();
        tick();
        checks++; if (speed_upgrade_p2 !== 1'b1 || frames_left !== 10'd2) begin errors++;
            $display("FAIL ga_pre: got up2=%0b frames=%0d expected 1,2", speed_upgrade_p2,
                     frames_left); end
        game_active = 1'b0;
        tick();
        checks++; if (speed_upgrade_p2 !== 1'b0 || frames_left !== 10'(SPAWN) ||
                      pu_visible !== 1'b0) begin errors++;
            $display("FAIL ga_low: got up2=%0b frames=%0d vis=%0b", speed_upgrade_p2,
                     frames_left, pu_visible); end
        game_active = 1'b1;
        for (int i = 1; i <= SPAWN; i++) begin
            tick();
            checks++; if (pu_visible !== (i == SPAWN)) begin errors++;
                $display("FAIL ga_respawn edge %0d: got %0b", i, pu_visible); end
        end
        checks++; if (pu_x !== 10'(m_pux) || pu_y !== 10'(m_puy)) begin errors++;
            $display("FAIL ga_pos: got %0d,%0d expected %0d,%0d", pu_x, pu_y, m_pux,
                     m_puy); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        far();
        wait_spawn();
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        checks++; if (pu_visible !== 1'b0 || pu_x !== 10'd0 || pu_y !== 10'd0 ||
                      frames_left !== 10'(SPAWN)) begin errors++;
            $display("FAIL areset_spawned: got vis=%0b pos=%0d,%0d frames=%0d", pu_visible,
                     pu_x, pu_y, frames_left); end
        @(negedge frame_clk);
        Reset = 1'b0;
        wait_spawn();
        checks++; if (pu_x !== 10'(m_pux) || pu_y !== 10'(m_puy)) begin errors++;
            $display("FAIL areset_seed: got %0d,%0d expected %0d,%0d", pu_x, pu_y, m_pux,
                     m_puy); end
        p1_x = 10'(m_pux); p1_y = 10'(m_puy);
        p2_x = 10'(m_pux); p2_y = 10'(m_puy);
        tick();
        far();
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        checks++; if (speed_upgrade_p1 !== 1'b0 || speed_upgrade_p2 !== 1'b0 ||
                      frames_left !== 10'(SPAWN)) begin errors++;
            $display("FAIL areset_active: got up=%0b%0b frames=%0d", speed_upgrade_p1,
                     speed_upgrade_p2, frames_left); end
        @(negedge frame_clk);
        Reset = 1'b0;
        wait_spawn();
        p1_x = 10'(m_pux); p1_y = 10'(m_puy);
        p2_x = 10'(m_pux); p2_y = 10'(m_puy);
        tick();
        checks++; if (speed_upgrade_p1 !== 1'b1 || speed_upgrade_p2 !== 1'b0) begin errors++;
            $display("FAIL areset_tie: got %0b%0b expected 10", speed_upgrade_p1,
                     speed_upgrade_p2); end
        far();
    endtask

    task automatic test_random();
        int off;
        for (int f = 0; f < 600; f++) begin
            game_active = ($urandom_range(0, 39) != 0);
            p1_s = 10'($urandom_range(0, 12));
            p2_s = 10'($urandom_range(0, 12));
            if ($urandom_range(0, 2) == 0) begin
                off = int'($urandom_range(0, 40)) - 20; p1_x = 10'(m_pux + off);
                off = int'($urandom_range(0, 40)) - 20; p1_y = 10'(m_puy + off);
            end else begin
                p1_x = 10'($urandom_range(0, 639)); p1_y = 10'($urandom_range(0, 479));
            end
            if ($urandom_range(0, 2) == 0) begin
                off = int'($urandom_range(0, 40)) - 20; p2_x = 10'(m_pux + off);
                off = int'($urandom_range(0, 40)) - 20; p2_y = 10'(m_puy + off);
            end else begin
                p2_x = 10'($urandom_range(0, 639)); p2_y = 10'($urandom_range(0, 479));
            end
            tick();
            checks++;
            if (pu_visible !== m_vis || pu_x !== 10'(m_pux) || pu_y !== 10'(m_puy) ||
                speed_upgrade_p1 !== m_up1 || speed_upgrade_p2 !== m_up2 ||
                frames_left !== 10'(m_cnt)) begin
                errors++;
                $display("FAIL random frame %0d: got vis=%0b pos=%0d,%0d up=%0b%0b cnt=%0d required vis=%0b pos=%0d,%0d up=%0b%0b cnt=%0d",
                         f, pu_visible, pu_x, pu_y, speed_upgrade_p1, speed_upgrade_p2,
                         frames_left, m_vis, m_pux, m_puy, m_up1, m_up2, m_cnt);
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        game_active = 1'b1;
        far();
        model_reset();
        test_reset();
        test_spawn();
        test_collect();
        test_tie();
        test_despawn();
        test_game_inactive();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/powerup_ctrl.md
Name: powerup_ctrl

Overview:
- Schedules the speed power-up shared by the two player tanks.
- Waits a spawn delay, then places a pickup at a pseudo-random on-screen position.
- Arbitrates which tank collects it, holds that tank's speed_upgrade high for a fixed number of frames, then restarts the cycle.
- Sits between both tank instances and the sprite/colour mapper; all logic steps once per frame_clk.

Parameters:
- SPAWN_DELAY, 600, frames spent in WAIT before a pickup appears (1..1023).
- DESPAWN_FRAMES, 450, frames an uncollected pickup stays visible (1..1023).
- ACTIVE_FRAMES, 300, frames speed_upgrade stays asserted for the collector (1..1023).
- PU_SIZE, 6, pickup half-width in pixels.
- LFSR_SEED, 16'hACE1, LFSR reset value (non-zero).

Ports:
- frame_clk  input  1  frame-rate clock
- Reset  input  1  reset, asynchronous, active-high
- game_active  input  1  high while a round is running
- p1_x, p1_y, p1_s  input  10 each  tank 1 centre and half-size
- p2_x, p2_y, p2_s  input  10 each  tank 2 centre and half-size
- pu_visible  output  1  pickup is on screen
- pu_x, pu_y  output  10 each  pickup centre
- speed_upgrade_p1  output  1  drives tank 1 speed_upgrade
- speed_upgrade_p2  output  1  drives tank 2 speed_upgrade
- frames_left  output  10  remaining count of the current state's counter

Behaviour:
Reset (reset Reset, asynchronous, active-high; clock frame_clk):
- state=WAIT, cnt=SPAWN_DELAY, lfsr=LFSR_SEED, tie_pri=0.
- pu_visible=0, pu_x=0, pu_y=0, both speed_upgrade=0, frames_left=SPAWN_DELAY.

Every frame_clk edge outside reset:
- LFSR: 16-bit Fibonacci, taps 16,14,13,11.
- Shift left; new bit0 = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
- Advances every edge regardless of state or game_active.

States:
- WAIT:
  - Decrement cnt.
  - If cnt==1: latch pu_x=64+{1'b0,lfsr[8:0]} (64..575) and pu_y=112+{2'b0,lfsr[15:8]} (112..367) from the pre-shift lfsr value.
  - Same edge: set pu_visible=1, cnt=DESPAWN_FRAMES, go to SPAWNED.
- SPAWNED:
  - hitN is true when both hold: |pN_x-pu_x| <= pN_s+PU_SIZE and |pN_y-pu_y| <= pN_s+PU_SIZE.
  - All subtraction and sum arithmetic is 11-bit unsigned with the absolute value taken, so there is no wrap.
  - Only hit1: winner P1.
  - Only hit2: winner P2.
  - Both hit: winner = tie_pri ? P2 : P1; then toggle tie_pri.
  - On a winner: pu_visible=0, speed_upgrade of the winner=1, cnt=ACTIVE_FRAMES, go to ACTIVE.
  - No hit and cnt==1: pu_visible=0, cnt=SPAWN_DELAY, go to WAIT.
  - No hit and cnt>1: decrement cnt.
  - Collision uses the input values present at the edge; latency from overlap to speed_upgrade is 1 edge.
- ACTIVE:
  - Decrement cnt.
  - If cnt==1: clear both speed_upgrade, cnt=SPAWN_DELAY, go to WAIT.
  - speed_upgrade is therefore high for exactly ACTIVE_FRAMES edges.
  - Pickup is never visible in ACTIVE. At most one speed_upgrade output is high at any time.

game_active low at an edge (synchronous, overrides all states):
- state=WAIT, cnt=SPAWN_DELAY, pu_visible=0, both speed_upgrade=0.
- pu_x, pu_y and tie_pri are held; LFSR keeps running.

Other rules:
- frames_left=cnt at all times.
- Asynchronous Reset mid-ACTIVE drops speed_upgrade immediately, without waiting for a clock edge.
- Parameter value 1 means exactly one frame in that state.

Test Plan:
1. SPAWN_DELAY=4, game_active=1, tanks far away (p1=(20,20), p2=(620,460), s=8) → pu_visible rises on the 4th edge after reset; pu_x/pu_y match the LFSR model (first spawn computed from the seed-advanced value); pu_x in 64..575, pu_y in 112..367.
2. After spawn, move p1 to (pu_x+14, pu_y), s=8 (edge of the 14-pixel reach) → next edge speed_upgrade_p1=1 and pu_visible=0. With ACTIVE_FRAMES=3, speed_upgrade_p1 is high for exactly 3 edges, then the block returns to WAIT with frames_left=SPAWN_DELAY. Repeat with the offset at 15 → no pickup.
3. Both tanks overlap the pickup on the same edge: first tie goes to P1, the next tie goes to P2, the third to P1 again.
4. DESPAWN_FRAMES=5, no tank approaches → pu_visible high for exactly 5 edges, then low; WAIT reloads to 4; both speed_upgrade stay 0 throughout.
5. game_active driven low during ACTIVE with cnt=2 → next edge speed_upgrade_p2=0, state WAIT, frames_left=SPAWN_DELAY. Raise game_active → normal spawn after SPAWN_DELAY edges.
6. Assert Reset asynchronously mid-SPAWNED and mid-ACTIVE → all outputs return to reset values before the next frame_clk edge; lfsr=16'hACE1 and tie_pri=0.
